// File: rtl/trisc_decode_stage.sv
// trisc_decode_stage: registered TRISC opcode decoder between fetch and execute.
// Output register plus a one-entry skid buffer, so the stage runs at full
// throughput while in_ready stays a flop. A saturating counter tracks the
// illegal beats delivered.
// Optional feature macro: DECODE_TRAP_EN. When it is defined, delivering an
// illegal beat parks the stage in TRAP until trap_clr is pulsed.
module trisc_decode_stage #(
    parameter int                        INSTR_W    = 8,
    parameter int                        OPCODE_W   = 4,
    parameter logic [(2**OPCODE_W)-1:0]  LEGAL_MASK = 16'h93DF,
    parameter int                        CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W-1:0]            in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [(2**OPCODE_W)-1:0]      out_onehot,
    output logic [OPCODE_W-1:0]           out_opcode,
    output logic [INSTR_W-OPCODE_W-1:0]   out_operand,
    output logic                          out_illegal,
    output logic [CNT_W-1:0]              illegal_cnt,
    input  logic                          trap_clr,
    output logic                          trap_active
);

    localparam int NOPS   = 2**OPCODE_W;
    localparam int OPND_W = INSTR_W - OPCODE_W;

    typedef struct packed {
        logic [NOPS-1:0]     onehot;
        logic [OPCODE_W-1:0] opcode;
        logic [OPND_W-1:0]   operand;
        logic                illegal;
    } beat_t;

    beat_t               dec_beat, out_q, out_d, skid_q, skid_d;
    logic                out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic                in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [OPCODE_W-1:0] dec_op;
    logic [NOPS-1:0]     dec_onehot;
    logic                accept, deliver, reg_free;
    logic                load_block;  // output reg may not load this edge (trap)
    logic                run_d;       // stage will be in RUN after this edge

    // ---------------- combinational decode ----------------
    assign dec_op = in_instr[INSTR_W-1 -: OPCODE_W];

    // Each one-hot bit can only fire for its own opcode, so the result is
    // one-hot or zero by construction.
    for (genvar k = 0; k < NOPS; k++) begin : g_onehot
        assign dec_onehot[k] = LEGAL_MASK[k] && (dec_op == OPCODE_W'(k));
    end

    assign dec_beat.onehot  = dec_onehot;
    assign dec_beat.opcode  = dec_op;
    assign dec_beat.operand = in_instr[OPND_W-1:0];
    assign dec_beat.illegal = !LEGAL_MASK[dec_op];

    // ---------------- handshake ----------------
    assign accept   = in_valid && in_rdy_q;
    assign deliver  = out_vld_q && out_ready;
    assign reg_free = !out_vld_q || out_ready;

`ifdef DECODE_TRAP_EN
    typedef enum logic {S_RUN, S_TRAP} state_t;
    state_t state_q, state_d;

    // Trap state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    // Enter TRAP on the edge that delivers an illegal beat. While trapped, the
    // output register is frozen so that a pending skid beat stays parked. The
    // clearing edge itself is allowed to move that beat out.
    always_comb begin
        state_d    = state_q;
        load_block = 1'b0;
        case (state_q)
            S_RUN: begin
                if (deliver && out_q.illegal) begin
                    state_d    = S_TRAP;
                    load_block = 1'b1;
                end
            end
            S_TRAP: begin
                if (trap_clr) state_d    = S_RUN;
                else          load_block = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign run_d       = (state_d == S_RUN);
    assign trap_active = (state_q == S_TRAP);
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign load_block      = 1'b0;
    assign run_d           = 1'b1;
    assign trap_active     = 1'b0;
`endif

    // Next state of the output register and the skid buffer. The skid buffer
    // always drains before any new beat, which keeps the beats in order.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (reg_free && !load_block) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_vld_d  = 1'b1;
                out_d      = dec_beat;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else begin
            // If the register was free but is blocked by the trap, the beat it
            // held has just been delivered, so it goes empty.
            if (reg_free) out_vld_d = 1'b0;
            if (accept) begin
                skid_vld_d = 1'b1;
                skid_d     = dec_beat;
            end
        end
        in_rdy_d = !skid_vld_d && run_d;
    end

    // Pipeline registers; in_ready is registered, not derived from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            in_rdy_q   <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    // Saturating count of illegal beats handed to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (deliver && out_q.illegal && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign in_ready    = in_rdy_q;
    assign out_valid   = out_vld_q;
    assign out_onehot  = out_q.onehot;
    assign out_opcode  = out_q.opcode;
    assign out_operand = out_q.operand;
    assign out_illegal = out_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_trisc_decode_stage.sv
// Directed bench for trisc_decode_stage: a default instance plus a CNT_W=2
// instance for counter saturation. The trap scenario follows DECODE_TRAP_EN.
module tb_trisc_decode_stage;

    localparam logic [15:0] MASK = 16'h93DF;

    logic        clk, rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
    logic        a_trap_clr, a_trap_active;
    logic [7:0]  a_in_instr, a_cnt;
    logic [15:0] a_onehot;
    logic [3:0]  a_opcode, a_operand;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_illegal;
    logic        c_trap_clr, c_trap_active;
    logic [7:0]  c_in_instr;
    logic [1:0]  c_cnt;
    logic [15:0] c_onehot;
    logic [3:0]  c_opcode, c_operand;

    int n_vec = 0;
    int n_err = 0;

    trisc_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_onehot(a_onehot), .out_opcode(a_opcode), .out_operand(a_operand),
        .out_illegal(a_illegal), .illegal_cnt(a_cnt),
        .trap_clr(a_trap_clr), .trap_active(a_trap_active)
    );

    trisc_decode_stage #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_instr(c_in_instr),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_onehot(c_onehot), .out_opcode(c_opcode), .out_operand(c_operand),
        .out_illegal(c_illegal), .illegal_cnt(c_cnt),
        .trap_clr(c_trap_clr), .trap_active(c_trap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_instr = '0; a_out_ready = 1; a_trap_clr = 0;
        c_in_valid = 0; c_in_instr = '0; c_out_ready = 1; c_trap_clr = 0;
        @(negedge clk); @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
        n_vec++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
        n_vec++; if (a_onehot !== 16'h0 || a_illegal !== 1'b0) begin n_err++; $display("FAIL rst_fields: got %h/%b want 0/0", a_onehot, a_illegal); end
        n_vec++; if (a_trap_active !== 1'b0) begin n_err++; $display("FAIL rst_trap: got %b want 0", a_trap_active); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: got rdy=%b vld=%b want 1/0", a_in_ready, a_out_valid); end
    endtask

    task automatic test_stream();
        logic [3:0]  op;
        logic [15:0] exp_oh;
        a_out_ready = 1; a_in_valid = 1; a_in_instr = 8'h00;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            op = 4'(i - 1);
            exp_oh = MASK[op] ? (16'h1 << op) : 16'h0;
            n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid beat %0d: got %b want 1", i-1, a_out_valid); end
            n_vec++; if (a_opcode !== op) begin n_err++; $display("FAIL stream_opcode beat %0d: got %h want %h", i-1, a_opcode, op); end
            n_vec++; if (a_onehot !== exp_oh) begin n_err++; $display("FAIL stream_onehot beat %0d: got %h want %h", i-1, a_onehot, exp_oh); end
            n_vec++; if (a_illegal !== !MASK[op]) begin n_err++; $display("FAIL stream_illegal beat %0d: got %b want %b", i-1, a_illegal, !MASK[op]); end
            n_vec++; if (a_operand !== 4'h0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_opnd_rdy beat %0d: got %h/%b want 0/1", i-1, a_operand, a_in_ready); end
            if (i == 5) begin n_vec++; if (a_onehot !== 16'h0010) begin n_err++; $display("FAIL stream_0x40: got %h want 0010", a_onehot); end end
            if (i == 6) begin n_vec++; if (a_onehot !== 16'h0 || a_illegal !== 1'b1) begin n_err++; $display("FAIL stream_0x50: got %h/%b want 0000/1", a_onehot, a_illegal); end end
            if (i < 16) a_in_instr = {4'(i), 4'h0};
            else        a_in_valid = 0;
        end
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", a_out_valid); end
        n_vec++; if (a_cnt !== 8'd5) begin n_err++; $display("FAIL stream_cnt: got %0d want 5", a_cnt); end
    endtask

    task automatic test_backpressure();
        a_out_ready = 0; a_in_valid = 1; a_in_instr = 8'hCA;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b1 || a_operand !== 4'hA || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first: got vld=%b opnd=%h rdy=%b want 1/a/1", a_out_valid, a_operand, a_in_ready); end
        a_in_instr = 8'hCB;
        @(negedge clk);
        n_vec++; if (a_in_ready !== 1'b0 || a_operand !== 4'hA) begin n_err++; $display("FAIL bp_skid: got rdy=%b opnd=%h want 0/a", a_in_ready, a_operand); end
        a_in_instr = 8'hCC;
        @(negedge clk);
        n_vec++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_operand !== 4'hA || a_onehot !== 16'h1000) begin n_err++; $display("FAIL bp_hold: got rdy=%b vld=%b opnd=%h oh=%h want 0/1/a/1000", a_in_ready, a_out_valid, a_operand, a_onehot); end
        a_out_ready = 1;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b1 || a_operand !== 4'hB || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second: got vld=%b opnd=%h rdy=%b want 1/b/1", a_out_valid, a_operand, a_in_ready); end
        a_in_valid = 0;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0 (0xCC must not be taken)", a_out_valid); end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 0; a_in_valid = 1; a_in_instr = 8'hCA;
        @(negedge clk);
        a_in_instr = 8'hCB;
        @(negedge clk);
        a_in_valid = 0;
        n_vec++; if (a_in_ready !== 1'b0 || a_cnt !== 8'd5) begin n_err++; $display("FAIL mid_pre: got rdy=%b cnt=%0d want 0/5", a_in_ready, a_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", a_cnt); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", a_in_ready); end
        @(negedge clk);
        rst_n = 1'b1; a_out_ready = 1;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL mid_after: got vld=%b rdy=%b want 0/1 (skid beat must be gone)", a_out_valid, a_in_ready); end
    endtask

    task automatic test_cnt_sat();
        logic [1:0] exp;
        c_out_ready = 1; c_in_valid = 1; c_in_instr = 8'hA3;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 5) c_in_valid = 0;
            if (j <= 5) begin
                n_vec++; if (c_out_valid !== 1'b1 || c_illegal !== 1'b1 || c_onehot !== 16'h0 || c_operand !== 4'h3) begin n_err++; $display("FAIL sat_beat %0d: got vld=%b ill=%b oh=%h opnd=%h want 1/1/0000/3", j, c_out_valid, c_illegal, c_onehot, c_operand); end
            end
            if (j >= 2 && j <= 6) begin
                exp = (j - 1 > 3) ? 2'd3 : 2'(j - 1);
                n_vec++; if (c_cnt !== exp) begin n_err++; $display("FAIL sat_cnt step %0d: got %0d want %0d", j, c_cnt, exp); end
            end
        end
        n_vec++; if (c_cnt !== 2'd3 || c_out_valid !== 1'b0) begin n_err++; $display("FAIL sat_final: got cnt=%0d vld=%b want 3/0", c_cnt, c_out_valid); end
    endtask

    task automatic test_trap();
        a_out_ready = 1; a_in_valid = 1; a_in_instr = 8'h12;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b1 || a_onehot !== 16'h0002 || a_operand !== 4'h2) begin n_err++; $display("FAIL trap_b0: got vld=%b oh=%h opnd=%h want 1/0002/2", a_out_valid, a_onehot, a_operand); end
        a_in_instr = 8'h57;
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b1 || a_illegal !== 1'b1 || a_onehot !== 16'h0 || a_operand !== 4'h7) begin n_err++; $display("FAIL trap_b1: got vld=%b ill=%b oh=%h opnd=%h want 1/1/0000/7", a_out_valid, a_illegal, a_onehot, a_operand); end
        a_in_instr = 8'h31;
        @(negedge clk);
`ifdef DECODE_TRAP_EN
        a_in_valid = 0;
        n_vec++; if (a_trap_active !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL trap_enter: got trap=%b vld=%b rdy=%b want 1/0/0", a_trap_active, a_out_valid, a_in_ready); end
        n_vec++; if (a_cnt !== 8'd1) begin n_err++; $display("FAIL trap_cnt: got %0d want 1", a_cnt); end
        @(negedge clk);
        n_vec++; if (a_trap_active !== 1'b1 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL trap_hold: got trap=%b vld=%b want 1/0", a_trap_active, a_out_valid); end
        a_trap_clr = 1;
        @(negedge clk);
        a_trap_clr = 0;
        n_vec++; if (a_trap_active !== 1'b0 || a_out_valid !== 1'b1 || a_onehot !== 16'h0008 || a_operand !== 4'h1) begin n_err++; $display("FAIL trap_release: got trap=%b vld=%b oh=%h opnd=%h want 0/1/0008/1", a_trap_active, a_out_valid, a_onehot, a_operand); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL trap_rdy: got %b want 1", a_in_ready); end
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL trap_drain: got %b want 0", a_out_valid); end
`else
        a_in_valid = 0; a_trap_clr = 1;
        n_vec++; if (a_trap_active !== 1'b0 || a_out_valid !== 1'b1 || a_onehot !== 16'h0008 || a_operand !== 4'h1) begin n_err++; $display("FAIL notrap_b2: got trap=%b vld=%b oh=%h opnd=%h want 0/1/0008/1", a_trap_active, a_out_valid, a_onehot, a_operand); end
        n_vec++; if (a_cnt !== 8'd1) begin n_err++; $display("FAIL notrap_cnt: got %0d want 1", a_cnt); end
        @(negedge clk);
        a_trap_clr = 0;
        n_vec++; if (a_trap_active !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL notrap_drain: got trap=%b vld=%b rdy=%b want 0/0/1", a_trap_active, a_out_valid, a_in_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_cnt_sat();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
